// File: rtl/move_link_ctrl_pkg.sv
// link_pkg: shared types and defaults for the move link controller.
package link_pkg;

  localparam int unsigned PktLen = 8;
  // Both nibbles exceed 8, so this code can never be a legal move.
  localparam logic [7:0] AckCodeDefault = 8'hAA;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StTxGap,
    StWaitAck,
    StErr
  } link_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/move_link_ctrl_if.sv
// move_link_ctrl_if: game-side and UART-side signals of the move link controller.
interface move_link_ctrl_if #(
  parameter int unsigned PKT_LEN = 8,
  parameter int unsigned RETRY_W = 2
);
  logic               move_req_in;
  logic [PKT_LEN-1:0] move_in;
  logic               rx_ready_in;
  logic [PKT_LEN-1:0] rx_data_in;
  logic               tx_trigger_out;
  logic [PKT_LEN-1:0] tx_data_out;
  logic               remote_valid_out;
  logic [PKT_LEN-1:0] remote_move_out;
  logic               move_done_out;
  logic               busy_out;
  logic               link_err_out;
  logic [RETRY_W-1:0] retry_count_out;

  // Controller side.
  modport slave (
    input  move_req_in, move_in, rx_ready_in, rx_data_in,
    output tx_trigger_out, tx_data_out, remote_valid_out, remote_move_out,
    output move_done_out, busy_out, link_err_out, retry_count_out
  );

  // Game FSM / UART side.
  modport master (
    output move_req_in, move_in, rx_ready_in, rx_data_in,
    input  tx_trigger_out, tx_data_out, remote_valid_out, remote_move_out,
    input  move_done_out, busy_out, link_err_out, retry_count_out
  );

endinterface

// File: rtl/move_link_ctrl_timer.sv
// link_timer: loadable down-counter; done is high for one cycle, load_val cycles after a load.
module link_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  assign done = run_q && (cnt_q == Width'(1));

  // Next count: a load restarts the timer, otherwise count down and stop at done.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q - Width'(1);
      if (done) run_d = 1'b0;
    end
  end

  // Counter state.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/move_link_ctrl.sv
// move_link_ctrl: arbitrates the single UART transmitter between local moves and ACKs,
// acknowledges remote moves, retransmits on ACK timeout and raises a sticky error.
// Optional build macro: LINK_DUP_FILTER_EN (re-ack but do not deliver retransmitted moves).
module move_link_ctrl #(
  parameter int unsigned        PKT_LEN       = link_pkg::PktLen,
  parameter int unsigned        TX_FRAME_CLKS = 67_710,
  parameter int unsigned        ACK_TIMEOUT   = 6_500_000,
  parameter int unsigned        MAX_RETRY     = 3,
  parameter logic [PKT_LEN-1:0] ACK_CODE      = PKT_LEN'(link_pkg::AckCodeDefault)
) (
  input logic             clk_in,
  input logic             rst_in_n,
  move_link_ctrl_if.slave link
);
  import link_pkg::*;

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam int unsigned TimerW = $clog2(max_u(TX_FRAME_CLKS, ACK_TIMEOUT) + 1);

  link_state_t        state_q, state_d;
  logic [PKT_LEN-1:0] move_q, move_d;
  logic               move_pend_q, move_pend_d;
  logic               inflight_q, inflight_d;
  logic               ack_pend_q, ack_pend_d;
  logic               sent_move_q, sent_move_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic               rx_valid_q;
  logic [PKT_LEN-1:0] rx_data_q;
  logic               tx_trigger_q, tx_trigger_d;
  logic [PKT_LEN-1:0] tx_data_q, tx_data_d;
  logic               remote_valid_q, remote_valid_d;
  logic [PKT_LEN-1:0] remote_move_q, remote_move_d;
  logic               move_done_q, move_done_d;
`ifdef LINK_DUP_FILTER_EN
  logic               expect_remote_q, expect_remote_d;
`endif

  logic              rx_is_ack, ack_hit, ack_set, deliver, move_accept;
  logic              timer_load, timer_done;
  logic [TimerW-1:0] timer_val;

  // Received packets are decoded one cycle after rx_ready_in (rx_valid_q stage).
  assign rx_is_ack   = (rx_data_q == ACK_CODE);
  // Any packet received while a move is in flight acknowledges it, except once failed.
  assign ack_hit     = rx_valid_q && inflight_q && (state_q != StErr);
  assign ack_set     = rx_valid_q && !rx_is_ack && (state_q != StErr);
`ifdef LINK_DUP_FILTER_EN
  assign deliver     = rx_valid_q && !rx_is_ack && expect_remote_q;
`else
  assign deliver     = rx_valid_q && !rx_is_ack;
`endif
  assign move_accept = link.move_req_in && !move_pend_q && (state_q != StErr);

  link_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Next-state, flag updates and registered output values.
  always_comb begin
    state_d        = state_q;
    move_d         = move_q;
    move_pend_d    = move_pend_q;
    inflight_d     = inflight_q;
    ack_pend_d     = ack_pend_q;
    sent_move_d    = sent_move_q;
    retry_d        = retry_q;
    tx_trigger_d   = 1'b0;
    tx_data_d      = tx_data_q;
    remote_valid_d = 1'b0;
    remote_move_d  = remote_move_q;
    move_done_d    = 1'b0;
    timer_load     = 1'b0;
    timer_val      = '0;
`ifdef LINK_DUP_FILTER_EN
    expect_remote_d = expect_remote_q;
`endif

    if (move_accept) begin
      move_d      = link.move_in;
      move_pend_d = 1'b1;
      retry_d     = '0;
    end

    if (deliver) begin
      remote_move_d  = rx_data_q;
      remote_valid_d = 1'b1;
`ifdef LINK_DUP_FILTER_EN
      expect_remote_d = 1'b0;
`endif
    end

    unique case (state_q)
      StIdle: begin
        if (ack_pend_q || move_pend_q) state_d = StSend;
      end
      StSend: begin
        // Packet choice is made here so an ACK that became pending meanwhile still wins.
        if (ack_pend_q || move_pend_q) begin
          tx_trigger_d = 1'b1;
          state_d      = StTxGap;
          timer_load   = 1'b1;
          // The SEND cycle itself is the first clock of the frame.
          timer_val    = TimerW'(TX_FRAME_CLKS - 1);
          if (ack_pend_q) begin
            tx_data_d   = ACK_CODE;
            ack_pend_d  = 1'b0;
            sent_move_d = 1'b0;
          end else begin
            tx_data_d   = move_q;
            inflight_d  = 1'b1;
            sent_move_d = 1'b1;
`ifdef LINK_DUP_FILTER_EN
            expect_remote_d = 1'b1;
`endif
          end
        end else begin
          state_d = StIdle;
        end
      end
      StTxGap: begin
        if (timer_done) begin
          if (sent_move_q && inflight_q && !ack_hit) begin
            state_d    = StWaitAck;
            timer_load = 1'b1;
            timer_val  = TimerW'(ACK_TIMEOUT);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWaitAck: begin
        // An ACK in the timeout cycle still counts.
        if (ack_hit) begin
          state_d = StIdle;
        end else if (timer_done) begin
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StIdle;
          end else begin
            state_d = StErr;
          end
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: state_d = StIdle;
    endcase

    // Applied after SEND so an acknowledgement always clears the in-flight move.
    if (ack_hit) begin
      move_pend_d = 1'b0;
      inflight_d  = 1'b0;
      move_done_d = 1'b1;
    end
    // Applied after SEND so a new ACK request is never lost to an ACK being sent.
    if (ack_set) ack_pend_d = 1'b1;
  end

  // State, flags, receive stage and output registers.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q        <= StIdle;
      move_q         <= '0;
      move_pend_q    <= 1'b0;
      inflight_q     <= 1'b0;
      ack_pend_q     <= 1'b0;
      sent_move_q    <= 1'b0;
      retry_q        <= '0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      tx_trigger_q   <= 1'b0;
      tx_data_q      <= '0;
      remote_valid_q <= 1'b0;
      remote_move_q  <= '0;
      move_done_q    <= 1'b0;
`ifdef LINK_DUP_FILTER_EN
      expect_remote_q <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      move_q         <= move_d;
      move_pend_q    <= move_pend_d;
      inflight_q     <= inflight_d;
      ack_pend_q     <= ack_pend_d;
      sent_move_q    <= sent_move_d;
      retry_q        <= retry_d;
      rx_valid_q     <= link.rx_ready_in;
      rx_data_q      <= link.rx_data_in;
      tx_trigger_q   <= tx_trigger_d;
      tx_data_q      <= tx_data_d;
      remote_valid_q <= remote_valid_d;
      remote_move_q  <= remote_move_d;
      move_done_q    <= move_done_d;
`ifdef LINK_DUP_FILTER_EN
      expect_remote_q <= expect_remote_d;
`endif
    end
  end

  assign link.tx_trigger_out   = tx_trigger_q;
  assign link.tx_data_out      = tx_data_q;
  assign link.remote_valid_out = remote_valid_q;
  assign link.remote_move_out  = remote_move_q;
  assign link.move_done_out    = move_done_q;
  assign link.busy_out         = move_pend_q;
  assign link.link_err_out     = (state_q == StErr);
  assign link.retry_count_out  = retry_q;

endmodule

// File: tb/tb_move_link_ctrl.sv
// tb_move_link_ctrl: vector table plus hand-written sequences for move_link_ctrl.
module tb_move_link_ctrl;

`ifdef LINK_DUP_FILTER_EN
  localparam bit DupFilt = 1'b1;
`else
  localparam bit DupFilt = 1'b0;
`endif
  localparam logic [7:0] Ack = 8'hAA;

  typedef struct {
    bit         is_move;
    logic [7:0] data;
    bit         exp_deliver;
    bit         exp_tx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rem[$];
  int         trig_cyc[$];
  int         trig_rty[$];
  int         rv_cyc[$];
  int         done_cyc[$];
  vec_t       vecs[6];

  move_link_ctrl_if #(.PKT_LEN(8), .RETRY_W(2)) link_if ();

  move_link_ctrl #(
    .TX_FRAME_CLKS (20),
    .ACK_TIMEOUT   (50),
    .MAX_RETRY     (3)
  ) dut (
    .clk_in   (clk),
    .rst_in_n (rst_n),
    .link     (link_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: pops expectations when the DUT produces a frame or a delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      if (link_if.tx_trigger_out) begin
        trig_cyc.push_back(cyc);
        trig_rty.push_back(int'(link_if.retry_count_out));
        if (exp_tx.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL tx_unexpected: got trigger with data %h, required none", link_if.tx_data_out);
        end else begin
          check("tx_data", link_if.tx_data_out, exp_tx.pop_front());
        end
      end
      if (link_if.remote_valid_out) begin
        rv_cyc.push_back(cyc);
        if (exp_rem.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL rv_unexpected: got delivery %h, required none", link_if.remote_move_out);
        end else begin
          check("remote_move", link_if.remote_move_out, exp_rem.pop_front());
        end
      end
      if (link_if.move_done_out) done_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] d);
    link_if.rx_ready_in = 1'b1;
    link_if.rx_data_in  = d;
    @(negedge clk);
    link_if.rx_ready_in = 1'b0;
  endtask

  task automatic send_move(input logic [7:0] d);
    link_if.move_req_in = 1'b1;
    link_if.move_in     = d;
    @(negedge clk);
    link_if.move_req_in = 1'b0;
  endtask

  // Bounded wait until at least target triggers have been seen.
  task automatic wait_trig(input int target, input int max_cyc, input string name);
    int n = 0;
    while (trig_cyc.size() < target && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    vec_cnt++;
    if (trig_cyc.size() < target) begin
      err_cnt++;
      $display("FAIL %s: got %0d triggers, required %0d", name, trig_cyc.size(), target);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n_tx0 = trig_cyc.size();
    int n_rv0 = rv_cyc.size();
    int n_done0 = done_cyc.size();
    int c, t;
    if (v.is_move) begin
      exp_tx.push_back(v.data);
      c = cyc;
      send_move(v.data);
      wait_trig(n_tx0 + 1, 10, "move_trigger");
      if (trig_cyc.size() > n_tx0) begin
        t = trig_cyc[n_tx0];
        check("move_latency", t - c, 3);
        check("busy_in_flight", link_if.busy_out, 1);
        wait_until(t + 29);
        c = cyc;
        send_rx(Ack);
        tick(3);
        check("done_count", done_cyc.size() - n_done0, 1);
        if (done_cyc.size() > n_done0) check("done_latency", done_cyc[n_done0] - c, 2);
        check("busy_after_ack", link_if.busy_out, 0);
        check("retry_after_ack", link_if.retry_count_out, 0);
      end
      tick(80);
      check("move_tx_count", trig_cyc.size() - n_tx0, 1);
    end else begin
      if (v.exp_deliver) exp_rem.push_back(v.data);
      if (v.exp_tx) exp_tx.push_back(Ack);
      c = cyc;
      send_rx(v.data);
      tick(40);
      check("rx_rv_count", rv_cyc.size() - n_rv0, v.exp_deliver);
      if (v.exp_deliver && rv_cyc.size() > n_rv0) check("rx_rv_latency", rv_cyc[n_rv0] - c, 2);
      check("rx_tx_count", trig_cyc.size() - n_tx0, v.exp_tx);
      if (v.exp_tx && trig_cyc.size() > n_tx0) check("rx_ack_latency", trig_cyc[n_tx0] - c, 4);
      check("rx_done_count", done_cyc.size() - n_done0, 0);
    end
  endtask

  initial begin
    int c, t, n_tx0, n_rv0, n_done0;
    link_if.move_req_in = 1'b0;
    link_if.move_in     = '0;
    link_if.rx_ready_in = 1'b0;
    link_if.rx_data_in  = '0;

    vecs[0] = '{is_move: 1'b1, data: 8'h34, exp_deliver: 1'b0, exp_tx: 1'b1};
    vecs[1] = '{is_move: 1'b0, data: 8'h56, exp_deliver: 1'b1, exp_tx: 1'b1};
    vecs[2] = '{is_move: 1'b0, data: 8'h01, exp_deliver: !DupFilt, exp_tx: 1'b1};
    vecs[3] = '{is_move: 1'b0, data: Ack, exp_deliver: 1'b0, exp_tx: 1'b0};
    vecs[4] = '{is_move: 1'b1, data: 8'h5A, exp_deliver: 1'b0, exp_tx: 1'b1};
    vecs[5] = '{is_move: 1'b0, data: 8'h01, exp_deliver: 1'b1, exp_tx: 1'b1};

    // Reset state.
    tick(3);
    check("rst_tx_trigger", link_if.tx_trigger_out, 0);
    check("rst_tx_data", link_if.tx_data_out, 0);
    check("rst_remote_valid", link_if.remote_valid_out, 0);
    check("rst_remote_move", link_if.remote_move_out, 0);
    check("rst_move_done", link_if.move_done_out, 0);
    check("rst_busy", link_if.busy_out, 0);
    check("rst_link_err", link_if.link_err_out, 0);
    check("rst_retry", link_if.retry_count_out, 0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Arbitration: remote move and local move in the same cycle; ACK goes first.
    n_tx0 = trig_cyc.size();
    n_rv0 = rv_cyc.size();
    exp_tx.push_back(Ack);
    exp_tx.push_back(8'h07);
    if (!DupFilt) exp_rem.push_back(8'h77);
    c = cyc;
    link_if.move_req_in = 1'b1;
    link_if.move_in     = 8'h07;
    link_if.rx_ready_in = 1'b1;
    link_if.rx_data_in  = 8'h77;
    @(negedge clk);
    link_if.move_req_in = 1'b0;
    link_if.rx_ready_in = 1'b0;
    wait_trig(n_tx0 + 2, 60, "arb_triggers");
    check("arb_rv_count", rv_cyc.size() - n_rv0, DupFilt ? 0 : 1);
    if (trig_cyc.size() >= n_tx0 + 2) begin
      check("arb_first_latency", trig_cyc[n_tx0] - c, 3);
      check("arb_spacing", trig_cyc[n_tx0 + 1] - trig_cyc[n_tx0], 21);
      t = trig_cyc[n_tx0 + 1];

      // Implicit ACK: remote move during WAIT_ACK completes the local move.
      wait_until(t + 25);
      n_tx0   = trig_cyc.size();
      n_rv0   = rv_cyc.size();
      n_done0 = done_cyc.size();
      exp_rem.push_back(8'h88);
      exp_tx.push_back(Ack);
      c = cyc;
      send_rx(8'h88);
      tick(3);
      check("impl_done_count", done_cyc.size() - n_done0, 1);
      check("impl_rv_count", rv_cyc.size() - n_rv0, 1);
      if (done_cyc.size() > n_done0) check("impl_done_latency", done_cyc[n_done0] - c, 2);
      if (rv_cyc.size() > n_rv0) check("impl_rv_latency", rv_cyc[n_rv0] - c, 2);
      check("impl_busy", link_if.busy_out, 0);
      tick(40);
      check("impl_tx_count", trig_cyc.size() - n_tx0, 1);

      // Repeated remote move: re-acknowledged; delivered only without the filter.
      n_tx0   = trig_cyc.size();
      n_rv0   = rv_cyc.size();
      n_done0 = done_cyc.size();
      exp_tx.push_back(Ack);
      if (!DupFilt) exp_rem.push_back(8'h88);
      send_rx(8'h88);
      tick(40);
      check("dup_rv_count", rv_cyc.size() - n_rv0, DupFilt ? 0 : 1);
      check("dup_tx_count", trig_cyc.size() - n_tx0, 1);
      check("dup_done_count", done_cyc.size() - n_done0, 0);
    end

    // Retry then error: no ACK ever arrives.
    n_tx0 = trig_cyc.size();
    for (int k = 0; k < 4; k++) exp_tx.push_back(8'h12);
    c = cyc;
    send_move(8'h12);
    wait_trig(n_tx0 + 4, 400, "retry_triggers");
    if (trig_cyc.size() >= n_tx0 + 4) begin
      check("retry_first_latency", trig_cyc[n_tx0] - c, 3);
      for (int k = 0; k < 4; k++) begin
        check("retry_count_at_tx", trig_rty[n_tx0 + k], k);
        if (k > 0) check("retry_spacing", trig_cyc[n_tx0 + k] - trig_cyc[n_tx0 + k - 1], 71);
      end
      t = trig_cyc[n_tx0 + 3];
      wait_until(t + 68);
      check("err_not_yet", link_if.link_err_out, 0);
      wait_until(t + 69);
      check("err_set", link_if.link_err_out, 1);
      check("err_retry", link_if.retry_count_out, 3);
      // In ERR: local moves ignored, remote moves delivered but not acknowledged.
      n_rv0 = rv_cyc.size();
      exp_rem.push_back(8'h3C);
      send_move(8'h99);
      tick(2);
      send_rx(8'h3C);
      tick(100);
      check("err_tx_count", trig_cyc.size() - n_tx0, 4);
      check("err_rv_count", rv_cyc.size() - n_rv0, 1);
      check("err_sticky", link_if.link_err_out, 1);
    end

    // Reset clears the error immediately.
    rst_n = 1'b0;
    #1;
    check("err_rst_link_err", link_if.link_err_out, 0);
    check("err_rst_retry", link_if.retry_count_out, 0);
    check("err_rst_remote_move", link_if.remote_move_out, 0);
    check("err_rst_busy", link_if.busy_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Async reset in the middle of TX_GAP.
    n_tx0 = trig_cyc.size();
    exp_tx.push_back(8'h21);
    send_move(8'h21);
    wait_trig(n_tx0 + 1, 10, "gap_trigger");
    tick(5);
    check("gap_tx_data_before", link_if.tx_data_out, 8'h21);
    #2 rst_n = 1'b0;
    #1;
    check("gap_rst_tx_data", link_if.tx_data_out, 0);
    check("gap_rst_tx_trigger", link_if.tx_trigger_out, 0);
    check("gap_rst_busy", link_if.busy_out, 0);
    check("gap_rst_link_err", link_if.link_err_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(100);
    check("gap_no_retrigger", trig_cyc.size() - n_tx0, 1);

    check("tx_expect_left", exp_tx.size(), 0);
    check("rv_expect_left", exp_rem.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
